// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI initiator: turns a req/resp memory port into one-beat
// AR/R reads or AW/W/B writes, with a one-cycle completion pulse.
module axi_lite_master_port #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  // Single-beat INCR transfers of full bus width; payload comes from the latched request.
  assign arid    = MASTER_ID;
  assign arlen   = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awid    = MASTER_ID;
  assign awlen   = 4'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  assign req_ready = (state == ST_IDLE);

  // NOTE: every register here is updated with <= so all reads in this block
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: default-low here makes resp_valid a single-cycle pulse without
      // needing a clear in every other state.
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_we) begin
              awvalid <= 1'b1;
              state   <= ST_AW;
            end else begin
              arvalid <= 1'b1;
              state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= rdata;
            resp_err   <= (rresp != 2'b00) || (rid != MASTER_ID) || !rlast;
            state      <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            state   <= ST_W;
          end
        end
        ST_W: begin
          if (wready) begin
            wvalid <= 1'b0;
            bready <= 1'b1;
            state  <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= (bresp != 2'b00) || (bid != MASTER_ID);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Bench for axi_lite_master_port: scripted reactive slave, a transaction-level
// expectation queue checked every cycle, and literal timing/value pins per scenario.
module tb_axi_lite_master_port;

  localparam logic [3:0] MID = 4'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  arid, awid, arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  axi_lite_master_port #(.MASTER_ID(MID), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave script for the current transaction: wait cycles per channel and returned fields.
  int          ar_d, r_d, aw_d, w_d, b_d;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_rid, s_bid;
  logic        s_rlast;

  task automatic set_cfg();
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
    s_rdata = 32'h0; s_rresp = 2'b00; s_bresp = 2'b00;
    s_rid = MID; s_bid = MID; s_rlast = 1'b1;
  endtask

  int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
  always @(negedge clk) begin
    if (arvalid) begin arready = (ar_c == ar_d); ar_c++; end else begin arready = 1'b0; ar_c = 0; end
    if (awvalid) begin awready = (aw_c == aw_d); aw_c++; end else begin awready = 1'b0; aw_c = 0; end
    if (wvalid)  begin wready  = (w_c == w_d);   w_c++;  end else begin wready  = 1'b0; w_c = 0;  end
    if (rready) begin rvalid = (r_c == r_d); r_c++; end else begin rvalid = 1'b0; r_c = 0; end
    if (bready) begin bvalid = (b_c == b_d); b_c++; end else begin bvalid = 1'b0; b_c = 0; end
    rdata = rvalid ? s_rdata : 32'h0;
    rresp = rvalid ? s_rresp : 2'b00;
    rid   = rvalid ? s_rid : 4'h0;
    rlast = rvalid ? s_rlast : 1'b0;
    bresp = bvalid ? s_bresp : 2'b00;
    bid   = bvalid ? s_bid : 4'h0;
  end

  // Transaction-level model: each accepted request yields one expected completion.
  typedef struct {
    int          exp_cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  logic [31:0] hold_rdata = '0;
  logic        hold_err = 1'b0;
  int last_acc = 0, last_resp = 0;
  int first_aw = -1, first_w = -1, first_b = -1;
  int arv_cnt = 0, brd_cnt = 0, resp_cnt = 0;
  logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  always begin
    @(negedge clk); #1;
    check("const_fields", {arid, arlen, arsize, arburst, awid, awlen, awsize, awburst, wlast},
          {MID, 4'd0, 3'b010, 2'b01, MID, 4'd0, 3'b010, 2'b01, 1'b1});
    if (rst) begin
      check("rst_outputs", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err, req_ready},
            8'b0000_0001);
      check("rst_rdata", resp_rdata, 32'h0);
      hold_rdata = '0; hold_err = 1'b0;
      {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
    end else begin
      check("req_ready", req_ready, (q.size() == 0) || (q[0].exp_cyc == cyc));
      if (arvalid) arv_cnt++;
      if (bready) brd_cnt++;
      if (awvalid && first_aw < 0) first_aw = cyc;
      if (wvalid && first_w < 0) first_w = cyc;
      if (bready && first_b < 0) first_b = cyc;
      if (arvalid || awvalid || wvalid) begin
        if (q.size() == 0) check("valid_without_request", {arvalid, awvalid, wvalid}, 3'b000);
        else begin
          if (arvalid) check("araddr", {q[0].we, araddr}, {1'b0, q[0].addr});
          if (awvalid) check("awaddr", {q[0].we, awaddr}, {1'b1, q[0].addr});
          if (wvalid)  check("wpayload", {q[0].we, wdata, wstrb}, {1'b1, q[0].wdata, q[0].wstrb});
        end
      end
      if (p_arv && !p_arr) check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_awv && !p_awr) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr)   check("w_stable", {wvalid, wdata, wstrb}, {1'b1, p_wdata, p_wstrb});
      if (resp_valid) begin
        resp_cnt++;
        last_resp = cyc;
        if (q.size() == 0) check("unexpected_resp_valid", 1'b1, 1'b0);
        else begin
          check("resp_cycle", cyc, q[0].exp_cyc);
          hold_rdata = q[0].rdata;
          hold_err   = q[0].err;
          void'(q.pop_front());
        end
      end else if (q.size() != 0 && cyc > q[0].exp_cyc) begin
        check("resp_missing", cyc, q[0].exp_cyc);
        void'(q.pop_front());
      end
      check("resp_hold", {resp_rdata, resp_err}, {hold_rdata, hold_err});
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  // Expected latency and result follow from the slave script alone.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    last_acc  = cyc;
    e.we      = we;
    e.addr    = a;
    e.wdata   = d;
    e.wstrb   = s;
    e.exp_cyc = cyc + (we ? 4 + aw_d + w_d + b_d : 3 + ar_d + r_d);
    e.rdata   = we ? 32'h0 : s_rdata;
    e.err     = we ? ((s_bresp != 2'b00) || (s_bid != MID))
                   : ((s_rresp != 2'b00) || (s_rid != MID) || !s_rlast);
    @(posedge clk); #1;
    q.push_back(e);
    if (!hold) begin
      req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_wstrb = ~s;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic clear_stats();
    first_aw = -1; first_w = -1; first_b = -1;
    arv_cnt = 0; brd_cnt = 0; resp_cnt = 0;
  endtask

  int acc0, acc1, wv_seen;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_cfg();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Zero-wait write: AW, W, B on consecutive cycles, completion four cycles after accept.
    set_cfg(); clear_stats();
    issue(1'b1, 32'h1000_0100, 32'h0000_0001, 4'hF, 1'b0);
    wait_done();
    check("t1_aw_cycle", first_aw - last_acc, 1);
    check("t1_w_cycle", first_w - last_acc, 2);
    check("t1_b_cycle", first_b - last_acc, 3);
    check("t1_resp_cycle", last_resp - last_acc, 4);
    check("t1_resp", {resp_rdata, resp_err}, {32'h0, 1'b0});

    // Read with ARREADY held off three cycles.
    set_cfg(); clear_stats();
    ar_d = 3; s_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h1000_0300, 32'h0, 4'h0, 1'b0);
    wait_done();
    check("t2_arvalid_cycles", arv_cnt, 4);
    check("t2_resp", {resp_rdata, resp_err}, {32'hDEAD_BEEF, 1'b0});
    check("t2_resp_cycle", last_resp - last_acc, 6);

    // Read with SLVERR.
    set_cfg(); clear_stats();
    s_rresp = 2'b10; s_rdata = 32'h1234_5678;
    issue(1'b0, 32'h1000_0304, 32'h0, 4'h0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    check("t3_resp", {resp_rdata, resp_err}, {32'h1234_5678, 1'b1});
    check("t3_resp_pulses", resp_cnt, 1);

    // Read with RLAST low is flagged as an error.
    set_cfg(); clear_stats();
    s_rlast = 1'b0; s_rdata = 32'hA5A5_0001; r_d = 2;
    issue(1'b0, 32'h2000_0000, 32'h0, 4'h0, 1'b0);
    wait_done();
    check("t3b_resp", {resp_rdata, resp_err}, {32'hA5A5_0001, 1'b1});

    // Write with BVALID delayed five cycles and a foreign BID.
    set_cfg(); clear_stats();
    b_d = 5; s_bid = MID + 4'd1; aw_d = 1; w_d = 2;
    issue(1'b1, 32'h1000_0108, 32'hCAFE_F00D, 4'h5, 1'b0);
    wait_done();
    check("t4_bready_cycles", brd_cnt, 6);
    check("t4_resp", {resp_rdata, resp_err}, {32'h0, 1'b1});
    check("t4_resp_cycle", last_resp - last_acc, 12);

    // Back-to-back reads with req_valid held: second accepted in the resp_valid cycle.
    set_cfg(); clear_stats();
    s_rdata = 32'h0000_0011;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'h0, 1'b1);
    acc0 = last_acc;
    issue(1'b0, 32'h3000_0004, 32'h0, 4'h0, 1'b0);
    acc1 = last_acc;
    wait_done();
    check("t5_second_accept", acc1 - acc0, 3);
    check("t5_total_cycles", last_resp - acc0, 6);
    check("t5_resp_pulses", resp_cnt, 2);

    // Reset while WVALID is up: outputs drop at once, no completion.
    set_cfg(); clear_stats();
    w_d = 50;
    issue(1'b1, 32'h1000_0200, 32'h5555_AAAA, 4'h3, 1'b0);
    wv_seen = 0;
    for (int i = 0; i < 20 && wv_seen == 0; i++) begin
      @(negedge clk); #1;
      if (wvalid) wv_seen = 1;
    end
    check("t6_reached_w", wv_seen, 1);
    #1 rst = 1'b1;
    q.delete();
    #1;
    check("t6_wvalid_drop", {wvalid, awvalid, bready, resp_valid}, 4'b0000);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("t6_idle_after", {req_ready, resp_valid, wvalid}, 3'b100);
    check("t6_no_completion", resp_cnt, 0);

    // A plain read afterwards still works.
    set_cfg(); clear_stats();
    s_rdata = 32'h0BAD_F00D; r_d = 1;
    issue(1'b0, 32'h4000_0010, 32'h0, 4'h0, 1'b0);
    wait_done();
    check("t7_resp", {resp_rdata, resp_err}, {32'h0BAD_F00D, 1'b0});

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
